// File: rtl/fpu_sqrt_ctrl_if.sv
// Operand/result handshake bundle for the square-root control stage.
// master drives operands and consumes results; slave is the controller.
interface fpu_sqrt_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [2:0]  in_rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_fflags;

    modport master (
        output in_valid, in_a, in_rm, out_ready,
        input  in_ready, out_valid, out_result, out_fflags
    );

    modport slave (
        input  in_valid, in_a, in_rm, out_ready,
        output in_ready, out_valid, out_result, out_fflags
    );
endinterface

// File: rtl/fpu_sqrt_ctrl.sv
// Control, special-case and round/pack stage for the binary32 sqrt datapath.
// One operation in flight; specials bypass the datapath entirely.
module fpu_sqrt_ctrl #(
    parameter int unsigned BIAS = 127
) (
    input  logic        clk,
    input  logic        reset,
    fpu_sqrt_ctrl_if.slave io,
    output logic        sq_start,
    output logic        sq_is_subnormal,
    output logic        sq_in_exp0,
    output logic [7:0]  sq_exp_half,
    output logic [23:0] sq_in_sig,
    input  logic        sq_done,
    input  logic [26:0] sq_sig,
    input  logic [7:0]  sq_exp,
    input  logic        sq_uf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ROUND,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        start_q, start_d;
    logic        valid_q, valid_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  flags_q, flags_d;
    logic [2:0]  rm_q, rm_d;
    logic        sub_q, sub_d;
    logic        exp0_q, exp0_d;
    logic [7:0]  half_q, half_d;
    logic [23:0] isig_q, isig_d;
    logic [25:0] dsig_q, dsig_d;
    logic [7:0]  dexp_q, dexp_d;
    logic        duf_q, duf_d;

    // The datapath hidden bit is implied by the exponent; it is not packed.
    logic unused_hidden;
    assign unused_hidden = sq_sig[26];

    logic        a_sign;
    logic [7:0]  a_exp;
    logic [22:0] a_frac;
    logic        exp_ones;
    logic        exp_zero;
    logic        frac_zero;
    logic        is_nan;
    logic        is_zero;
    logic        is_inf;
    logic        is_sub;
    logic        is_special;
    logic [8:0]  exp_sum;
    logic [31:0] spec_res;
    logic [4:0]  spec_flags;

    assign a_sign     = io.in_a[31];
    assign a_exp      = io.in_a[30:23];
    assign a_frac     = io.in_a[22:0];
    assign exp_ones   = &a_exp;
    assign exp_zero   = ~|a_exp;
    assign frac_zero  = ~|a_frac;
    assign is_nan     = exp_ones & ~frac_zero;
    assign is_inf     = exp_ones & frac_zero;
    assign is_zero    = exp_zero & frac_zero;
    assign is_sub     = exp_zero & ~frac_zero;
    assign is_special = is_nan | is_inf | is_zero | a_sign;
    assign exp_sum    = {1'b0, a_exp} + 9'(BIAS);

    // Result and flags for operands that never reach the datapath.
    always_comb begin
        spec_res   = 32'h7FC0_0000;
        spec_flags = 5'b00000;
        if (is_nan) begin
            spec_flags = {~a_frac[22], 4'b0000};
        end else if (is_zero) begin
            spec_res = io.in_a;
        end else if (a_sign) begin
            spec_flags = 5'b10000;
        end else begin
            spec_res = 32'h7F80_0000;
        end
    end

    logic        rnd_g;
    logic        rnd_r;
    logic        rnd_s;
    logic        rnd_nx;
    logic        rnd_up;
    logic [30:0] rnd_sum;

    assign rnd_g   = dsig_q[2];
    assign rnd_r   = dsig_q[1];
    assign rnd_s   = dsig_q[0];
    assign rnd_nx  = rnd_g | rnd_r | rnd_s;
    assign rnd_sum = {dexp_q, dsig_q[25:3]} + {30'd0, rnd_up};

    // Round-up decision; the result is never negative, so RDN truncates.
    always_comb begin
        rnd_up = rnd_g & (rnd_r | rnd_s | dsig_q[3]);
        unique case (rm_q)
            3'b001:  rnd_up = 1'b0;
            3'b010:  rnd_up = 1'b0;
            3'b011:  rnd_up = rnd_nx;
            3'b100:  rnd_up = rnd_g;
            default: rnd_up = rnd_g & (rnd_r | rnd_s | dsig_q[3]);
        endcase
    end

    // Next-state and registered-output logic of the control FSM.
    always_comb begin
        state_d    = state_q;
        in_ready_d = in_ready_q;
        start_d    = 1'b0;
        valid_d    = valid_q;
        res_d      = res_q;
        flags_d    = flags_q;
        rm_d       = rm_q;
        sub_d      = sub_q;
        exp0_d     = exp0_q;
        half_d     = half_q;
        isig_d     = isig_q;
        dsig_d     = dsig_q;
        dexp_d     = dexp_q;
        duf_d      = duf_q;
        unique case (state_q)
            S_IDLE: begin
                if (io.in_valid && in_ready_q) begin
                    rm_d       = io.in_rm;
                    in_ready_d = 1'b0;
                    if (is_special) begin
                        res_d   = spec_res;
                        flags_d = spec_flags;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        sub_d   = is_sub;
                        exp0_d  = is_sub | a_exp[0];
                        half_d  = is_sub ? 8'd64 : exp_sum[8:1];
                        isig_d  = {~is_sub, a_frac};
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sq_done) begin
                    dsig_d  = sq_sig[25:0];
                    dexp_d  = sq_exp;
                    duf_d   = sq_uf;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                res_d   = {1'b0, rnd_sum};
                flags_d = {3'b000, duf_q & rnd_nx, rnd_nx};
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (io.out_ready) begin
                    valid_d    = 1'b0;
                    in_ready_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                valid_d    = 1'b0;
                in_ready_d = 1'b1;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and operand/result registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            res_q      <= '0;
            flags_q    <= '0;
            rm_q       <= '0;
            sub_q      <= 1'b0;
            exp0_q     <= 1'b0;
            half_q     <= '0;
            isig_q     <= '0;
            dsig_q     <= '0;
            dexp_q     <= '0;
            duf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
            res_q      <= res_d;
            flags_q    <= flags_d;
            rm_q       <= rm_d;
            sub_q      <= sub_d;
            exp0_q     <= exp0_d;
            half_q     <= half_d;
            isig_q     <= isig_d;
            dsig_q     <= dsig_d;
            dexp_q     <= dexp_d;
            duf_q      <= duf_d;
        end
    end

    assign io.in_ready      = in_ready_q;
    assign io.out_valid     = valid_q;
    assign io.out_result    = res_q;
    assign io.out_fflags    = flags_q;
    assign sq_start         = start_q;
    assign sq_is_subnormal  = sub_q;
    assign sq_in_exp0       = exp0_q;
    assign sq_exp_half      = half_q;
    assign sq_in_sig        = isig_q;

endmodule
